parking_occupancy: RTL and testbench

Parking-lot occupancy tracker that feeds the four-digit seven-segment display multiplexer. It synchronizes two optical beam sensors, decodes car entry and exit sequences with a direction FSM, and keeps a saturating 4-digit BCD occupancy count. It drives four registered, active-low segment patterns (`sseg3`..`sseg0`) that connect directly to the display multiplexer inputs `in3`..`in0`.

---
 rtl/parking_occupancy_pkg.sv | 56 +++++
 rtl/parking_occupancy_bcd_updown4.sv | 47 ++++
 rtl/parking_occupancy.sv | 147 ++++++++++++++
 tb/tb_parking_occupancy.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/parking_occupancy_pkg.sv
// rtl/parking_occupancy_pkg.sv - shared FSM states, segment constants and helpers
package parking_occupancy_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_E1   = 3'd1,
    ST_E2   = 3'd2,
    ST_E3   = 3'd3,
    ST_X1   = 3'd4,
    ST_X2   = 3'd5,
    ST_X3   = 3'd6,
    ST_WAIT = 3'd7
  } state_t;

  // Active-low patterns: bit 7 = dp, bits 6:0 = g..a
  localparam logic [7:0] SSEG_BLANK = 8'hFF;
  localparam logic [7:0] SSEG_0 = 8'hC0;
  localparam logic [7:0] SSEG_1 = 8'hF9;
  localparam logic [7:0] SSEG_2 = 8'hA4;
  localparam logic [7:0] SSEG_3 = 8'hB0;
  localparam logic [7:0] SSEG_4 = 8'h99;
  localparam logic [7:0] SSEG_5 = 8'h92;
  localparam logic [7:0] SSEG_6 = 8'h82;
  localparam logic [7:0] SSEG_7 = 8'hF8;
  localparam logic [7:0] SSEG_8 = 8'h80;
  localparam logic [7:0] SSEG_9 = 8'h90;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] seg;
    case (digit)
      4'd0:    seg = SSEG_0;
      4'd1:    seg = SSEG_1;
      4'd2:    seg = SSEG_2;
      4'd3:    seg = SSEG_3;
      4'd4:    seg = SSEG_4;
      4'd5:    seg = SSEG_5;
      4'd6:    seg = SSEG_6;
      4'd7:    seg = SSEG_7;
      4'd8:    seg = SSEG_8;
      4'd9:    seg = SSEG_9;
      default: seg = SSEG_BLANK;
    endcase
    return seg;
  endfunction

  // Elaboration-time only: converts the binary capacity parameter to BCD
  function automatic logic [15:0] bin_to_bcd(input int unsigned value);
    logic [15:0] bcd;
    bcd[3:0]   = 4'(value % 10);
    bcd[7:4]   = 4'((value / 10) % 10);
    bcd[11:8]  = 4'((value / 100) % 10);
    bcd[15:12] = 4'((value / 1000) % 10);
    return bcd;
  endfunction

endpackage

// File: rtl/parking_occupancy_bcd_updown4.sv
// rtl/parking_occupancy_bcd_updown4.sv - 4-digit BCD up/down counter with digit carry/borrow
module bcd_updown4 (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inc,
  input  logic        dec,
  output logic [15:0] count
);

  logic [15:0] count_d;
  logic        carry;
  logic        borrow;

  // Ripple a carry or borrow through the digits; a digit only changes when it receives one
  always_comb begin
    count_d = count;
    carry   = inc & ~dec;
    borrow  = dec & ~inc;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (count[4*i +: 4] == 4'd9) begin
          count_d[4*i +: 4] = 4'd0;
        end else begin
          count_d[4*i +: 4] = count[4*i +: 4] + 4'd1;
          carry = 1'b0;
        end
      end
      if (borrow) begin
        if (count[4*i +: 4] == 4'd0) begin
          count_d[4*i +: 4] = 4'd9;
        end else begin
          count_d[4*i +: 4] = count[4*i +: 4] - 4'd1;
          borrow = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 16'h0000;
    end else begin
      count <= count_d;
    end
  end

endmodule

// File: rtl/parking_occupancy.sv
// rtl/parking_occupancy.sv - beam-sensor direction FSM, BCD occupancy count and display encode
module parking_occupancy
  import parking_occupancy_pkg::*;
#(
  parameter int unsigned CAP = 25
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        sensor_a,
  input  logic        sensor_b,
  output logic        enter,
  output logic        exit,
  output logic        reject,
  output logic [15:0] occ,
  output logic        full,
  output logic        empty,
  output logic [7:0]  sseg3,
  output logic [7:0]  sseg2,
  output logic [7:0]  sseg1,
  output logic [7:0]  sseg0
);

  localparam logic [15:0] CAP_BCD = bin_to_bcd(CAP);

  logic [1:0] sync1, sync2;
  state_t     state_q, state_d;
  logic       entry_evt, exit_evt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 2'b00;
      sync2 <= 2'b00;
    end else begin
      sync1 <= {sensor_a, sensor_b};
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // sync2 = {a,b}; the exit path is the entry path with a and b swapped
  always_comb begin
    state_d   = state_q;
    entry_evt = 1'b0;
    exit_evt  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (sync2 == 2'b10) state_d = ST_E1;
        else if (sync2 == 2'b01) state_d = ST_X1;
        else if (sync2 == 2'b11) state_d = ST_WAIT;
      end
      ST_E1: begin
        if (sync2 == 2'b11) state_d = ST_E2;
        else if (sync2 == 2'b00) state_d = ST_IDLE;
        else if (sync2 == 2'b01) state_d = ST_WAIT;
      end
      ST_E2: begin
        if (sync2 == 2'b01) state_d = ST_E3;
        else if (sync2 == 2'b10) state_d = ST_E1;
        else if (sync2 == 2'b00) state_d = ST_WAIT;
      end
      ST_E3: begin
        if (sync2 == 2'b00) begin
          state_d   = ST_IDLE;
          entry_evt = 1'b1;
        end else if (sync2 == 2'b11) state_d = ST_E2;
        else if (sync2 == 2'b10) state_d = ST_WAIT;
      end
      ST_X1: begin
        if (sync2 == 2'b11) state_d = ST_X2;
        else if (sync2 == 2'b00) state_d = ST_IDLE;
        else if (sync2 == 2'b10) state_d = ST_WAIT;
      end
      ST_X2: begin
        if (sync2 == 2'b10) state_d = ST_X3;
        else if (sync2 == 2'b01) state_d = ST_X1;
        else if (sync2 == 2'b00) state_d = ST_WAIT;
      end
      ST_X3: begin
        if (sync2 == 2'b00) begin
          state_d  = ST_IDLE;
          exit_evt = 1'b1;
        end else if (sync2 == 2'b11) state_d = ST_X2;
        else if (sync2 == 2'b01) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sync2 == 2'b00) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Events are at least four cycles apart, so occ has settled before the next decision
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enter  <= 1'b0;
      exit   <= 1'b0;
      reject <= 1'b0;
    end else begin
      enter  <= entry_evt & ~full;
      exit   <= exit_evt & ~empty;
      reject <= (entry_evt & full) | (exit_evt & empty);
    end
  end

  bcd_updown4 u_count (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (enter),
    .dec     (exit),
    .count   (occ)
  );

  assign full  = (occ == CAP_BCD);
  assign empty = (occ == 16'h0000);

  logic [3:0] d3, d2, d1, d0;
  logic [7:0] seg0_raw;

  assign d3       = occ[15:12];
  assign d2       = occ[11:8];
  assign d1       = occ[7:4];
  assign d0       = occ[3:0];
  assign seg0_raw = seg_encode(d0);

  // Leading-zero blanking on the upper three digits; dp on the units digit flags a full lot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sseg3 <= SSEG_BLANK;
      sseg2 <= SSEG_BLANK;
      sseg1 <= SSEG_BLANK;
      sseg0 <= SSEG_0;
    end else begin
      sseg3 <= (d3 == 4'd0) ? SSEG_BLANK : seg_encode(d3);
      sseg2 <= (d3 == 4'd0 && d2 == 4'd0) ? SSEG_BLANK : seg_encode(d2);
      sseg1 <= (d3 == 4'd0 && d2 == 4'd0 && d1 == 4'd0) ? SSEG_BLANK : seg_encode(d1);
      sseg0 <= {~full, seg0_raw[6:0]};
    end
  end

endmodule

// File: tb/tb_parking_occupancy.sv
// tb/tb_parking_occupancy.sv - self-checking bench for parking_occupancy
module tb_parking_occupancy;

  localparam int CAP = 25;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        sensor_a = 1'b0;
  logic        sensor_b = 1'b0;
  logic        enter, exit, reject, full, empty;
  logic [15:0] occ;
  logic [7:0]  sseg3, sseg2, sseg1, sseg0;

  int checks = 0;
  int errors = 0;
  int n_enter = 0;
  int n_exit = 0;
  int n_reject = 0;
  int model_occ = 0;

  parking_occupancy #(.CAP(CAP)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .sensor_a (sensor_a),
    .sensor_b (sensor_b),
    .enter    (enter),
    .exit     (exit),
    .reject   (reject),
    .occ      (occ),
    .full     (full),
    .empty    (empty),
    .sseg3    (sseg3),
    .sseg2    (sseg2),
    .sseg1    (sseg1),
    .sseg0    (sseg0)
  );

  always #10 clk = ~clk;

  always @(negedge clk) begin
    if (enter)  n_enter++;
    if (exit)   n_exit++;
    if (reject) n_reject++;
  end

  function automatic logic [7:0] seg_of(input int d);
    case (d)
      0: return 8'hC0;
      1: return 8'hF9;
      2: return 8'hA4;
      3: return 8'hB0;
      4: return 8'h99;
      5: return 8'h92;
      6: return 8'h82;
      7: return 8'hF8;
      8: return 8'h80;
      default: return 8'h90;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input int v, input int idx);
    int p;
    logic [7:0] s;
    p = (idx == 0) ? 1 : (idx == 1) ? 10 : (idx == 2) ? 100 : 1000;
    if (idx > 0 && v < p) return 8'hFF;
    s = seg_of((v / p) % 10);
    if (idx == 0 && v == CAP) s[7] = 1'b0;
    return s;
  endfunction

  function automatic logic [15:0] bcd_of(input int v);
    return 16'((((v / 1000) % 10) << 12) | (((v / 100) % 10) << 8) | (((v / 10) % 10) << 4) | (v % 10));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_occ"}, 32'(occ), 32'(bcd_of(model_occ)));
    chk({tag, "_full"}, 32'(full), 32'(model_occ == CAP));
    chk({tag, "_empty"}, 32'(empty), 32'(model_occ == 0));
    chk({tag, "_sseg3"}, 32'(sseg3), 32'(exp_seg(model_occ, 3)));
    chk({tag, "_sseg2"}, 32'(sseg2), 32'(exp_seg(model_occ, 2)));
    chk({tag, "_sseg1"}, 32'(sseg1), 32'(exp_seg(model_occ, 1)));
    chk({tag, "_sseg0"}, 32'(sseg0), 32'(exp_seg(model_occ, 0)));
  endtask

  task automatic step(input logic [1:0] p, input int n);
    {sensor_a, sensor_b} = p;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // kind: 0 entry, 1 exit, 2 abort back out, 3 abort via WAIT
  task automatic do_seq(input int kind, input int hold, input string tag);
    int e0, x0, r0, de, dx, dr;
    e0 = n_enter; x0 = n_exit; r0 = n_reject;
    de = 0; dx = 0; dr = 0;
    case (kind)
      0: begin step(2'b10, hold); step(2'b11, hold); step(2'b01, hold); step(2'b00, hold); end
      1: begin step(2'b01, hold); step(2'b11, hold); step(2'b10, hold); step(2'b00, hold); end
      2: begin step(2'b10, hold); step(2'b11, hold); step(2'b10, hold); step(2'b00, hold); end
      default: begin step(2'b10, hold); step(2'b01, hold); step(2'b00, hold); end
    endcase
    step(2'b00, 6);
    if (kind == 0) begin
      if (model_occ < CAP) begin model_occ++; de = 1; end else dr = 1;
    end else if (kind == 1) begin
      if (model_occ > 0) begin model_occ--; dx = 1; end else dr = 1;
    end
    chk({tag, "_enter_cnt"}, 32'(n_enter - e0), 32'(de));
    chk({tag, "_exit_cnt"}, 32'(n_exit - x0), 32'(dx));
    chk({tag, "_reject_cnt"}, 32'(n_reject - r0), 32'(dr));
    check_state(tag);
  endtask

  initial begin
    int kind;
    int e0, x0, r0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_enter", 32'(enter), 32'd0);
    chk("rst_exit", 32'(exit), 32'd0);
    chk("rst_reject", 32'(reject), 32'd0);
    check_state("rst");
    reset_n = 1'b1;
    step(2'b00, 2);

    // Entry with exact latency after the final change to 00
    step(2'b10, 4); step(2'b11, 4); step(2'b01, 4);
    {sensor_a, sensor_b} = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("lat_enter_pulse", 32'(enter), 32'd1);
    @(posedge clk); #1;
    chk("lat_occ", 32'(occ), 32'h0001);
    chk("lat_sseg0_old", 32'(sseg0), 32'hC0);
    @(posedge clk); #1;
    chk("lat_sseg0_new", 32'(sseg0), 32'hF9);
    model_occ = 1;
    step(2'b00, 4);
    chk("first_enter_cnt", 32'(n_enter), 32'd1);
    check_state("first");

    do_seq(1, 4, "exit1");
    do_seq(2, 4, "abort_back");
    do_seq(3, 4, "abort_wait");
    do_seq(1, 3, "rej_empty");

    for (int i = 0; i < 9; i++) do_seq(0, 2, "nine");
    do_seq(0, 3, "tenth");
    chk("tenth_occ_bcd", 32'(occ), 32'h0010);
    chk("tenth_sseg1", 32'(sseg1), 32'hF9);
    do_seq(1, 2, "to_nine");
    chk("nine_sseg1", 32'(sseg1), 32'hFF);

    while (model_occ < CAP) do_seq(0, $urandom_range(1, 4), "fill");
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_sseg1", 32'(sseg1), 32'hA4);
    chk("fill_sseg0", 32'(sseg0), 32'h12);
    do_seq(0, 2, "over_cap");
    chk("over_cap_occ", 32'(occ), 32'h0025);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 4);
      if (kind == 4) kind = 1;
      do_seq(kind, $urandom_range(1, 4), "rand");
    end

    // Reset while the FSM sits in E2
    step(2'b10, 4); step(2'b11, 4);
    reset_n = 1'b0;
    #1;
    model_occ = 0;
    chk("midrst_enter", 32'(enter), 32'd0);
    chk("midrst_exit", 32'(exit), 32'd0);
    chk("midrst_reject", 32'(reject), 32'd0);
    check_state("midrst");
    @(posedge clk); #1;
    reset_n = 1'b1;
    e0 = n_enter; x0 = n_exit; r0 = n_reject;
    step(2'b11, 3); step(2'b01, 4); step(2'b00, 8);
    chk("post_rst_enter", 32'(n_enter - e0), 32'd0);
    chk("post_rst_exit", 32'(n_exit - x0), 32'd0);
    chk("post_rst_reject", 32'(n_reject - r0), 32'd0);
    check_state("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
